fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction fetch stage of the MIPS core, directly upstream of the main decoder. It holds the PC and issues requests to instruction memory over a req/ready handshake. It registers each fetched word into an IF/ID output register whose opcode field drives the decoder's op input. It honours downstream stall and branch/jump redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word presented when the output is invalid or flushed.

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
imem_req  output  1  fetch request; held high with stable imem_addr until imem_ready is sampled high.
imem_addr  output  32  word-aligned fetch address, bits [1:0] always 0.
imem_ready  input  1  memory has returned data this cycle; may be high in the first request cycle.
imem_rdata  input  32  instruction word, valid when imem_ready is high.
stall  input  1  decode cannot accept; hold if_instr, if_pc4 and if_valid.
redirect_valid  input  1  branch taken or jump resolved; flush and refetch.
redirect_pc  input  32  target PC; bits [1:0] ignored and forced to 0.
if_instr  output  32  registered instruction; NOP_INSTR when if_valid is 0.
if_op  output  6  if_instr[31:26], the decoder op input.
if_pc4  output  32  PC of if_instr plus 4.
if_valid  output  1  if_instr holds a live instruction.

Behaviour:
- Reset, asynchronous: pc=RESET_PC, state=IDLE, imem_req=0, if_valid=0, if_instr=NOP_INSTR, if_pc4=0, skid empty.
- States: IDLE, REQ, DROP, WAIT. imem_req=1 in REQ and DROP only. imem_addr=pc in REQ and the held drop address in DROP.
- IDLE: unconditionally goes to REQ next cycle. The first request is therefore one cycle after reset release.
- REQ, imem_ready=1, no redirect: the word is accepted and pc<=pc+4, wrapping mod 2^32.
  - If the output register is free (!if_valid or !stall), load if_instr, if_pc4=pc+4, if_valid=1.
  - Otherwise write the word into the one-entry skid, then go to WAIT.
  - Sustained throughput is one instruction per cycle when imem_ready is held high.
- REQ, imem_ready=0, no redirect: stay in REQ; address unchanged.
- WAIT: no request. When decode consumes (if_valid and !stall), skid moves to the output register next cycle and the state goes to REQ.
- Consume rule: when the output is consumed, there is no new word and the skid is empty, if_valid<=0 and if_instr<=NOP_INSTR.
- redirect_valid has priority over stall and imem_ready. On any cycle it is high:
  - if_valid<=0, if_instr<=NOP_INSTR, skid cleared, pc<={redirect_pc[31:2],2'b00}.
  - In REQ with imem_ready=0, latch the current address as the drop address and go to DROP.
  - In REQ with imem_ready=1, discard the returned word and stay in REQ, fetching the new pc next cycle.
  - In WAIT or IDLE, go to REQ.
- DROP: keep the request to the drop address until imem_ready. Discard that data, then go to REQ with the current pc. A further redirect in DROP only updates pc.
- Fetch order: no instruction fetched after a redirect reaches the output before the target instruction.
- Stall with if_valid=0 has no effect on the output; it is loaded normally.
- Reset asserted mid-request drops imem_req asynchronously. The memory side must tolerate abandonment.

Decomposition:
- Package mips_fetch_pkg: state enum (IDLE, REQ, DROP, WAIT), NOP_INSTR default, OP_MSB=31 and OP_LSB=26 constants, PC width 32.
- One natural sub-module: fetch_skid, a one-entry skid register holding instr and pc4, with a valid flag plus load/drain/clear controls. The FSM, PC and output register stay in fetch_stage.

Test Plan:
- Reset release, imem_ready tied 1, memory word[i]=i: imem_addr 0,4,8,... on consecutive cycles; if_pc4 4,8,12; if_valid high from the 3rd cycle after release; if_op=rdata[31:26].
- imem_ready low for 3 cycles at addr 0x10: imem_req and imem_addr=0x10 stable for all 4 cycles; the word appears once; no duplicate and no skip.
- stall high 4 cycles during a streaming fetch: if_instr frozen; one extra word held in the skid; imem_req low in WAIT; on release, words continue in order with none lost.
- redirect_valid with redirect_pc=0x0000_0103 while a request to 0x20 is pending: state DROP, 0x20 data discarded; next fetch address 0x100; first valid if_pc4=0x104.
- redirect and stall high in the same cycle with the skid full: the output flushes to NOP_INSTR/if_valid=0, the skid is cleared, and fetch of the target begins next cycle.
- rst_n pulsed low mid-DROP: immediately imem_req=0, if_valid=0, pc=RESET_PC; restart matches the first scenario.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_fetch_pkg
// Description : Shared types and constants for the MIPS instruction fetch
//               stage: fetch FSM state encoding, PC width, opcode field
//               position, default NOP word and a word-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_fetch_pkg;

    localparam int PC_W   = 32;
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;

    localparam logic [PC_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [PC_W-1:0] RESET_PC_DEF  = 32'h0000_0000;

    // IDLE : one idle cycle after reset release
    // REQ  : request outstanding to the current PC
    // DROP : request outstanding to a stale address whose data is discarded
    // WAIT : output register and skid both full, no request
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        WAIT = 2'd3
    } fetch_state_t;

    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory request/ready bus between the fetch stage
//               (master) and instruction memory (slave).
//   imem_req   : fetch request, held with stable imem_addr until imem_ready
//   imem_addr  : word-aligned fetch address
//   imem_ready : data returned this cycle
//   imem_rdata : instruction word, valid with imem_ready
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid
// Description : One-entry skid register holding a fetched instruction and its
//               PC+4 while the IF/ID output register is stalled.
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_load           : capture i_instr / i_pc4, mark entry valid
//   i_drain          : entry moved downstream, mark empty
//   i_clear          : flush, mark empty (highest priority)
//   o_valid          : entry holds a word
//   o_instr, o_pc4   : held word and its PC+4
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid
    import mips_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_drain,
    input  logic            i_clear,
    input  logic [31:0]     i_instr,
    input  logic [PC_W-1:0] i_pc4,
    output logic            o_valid,
    output logic [31:0]     o_instr,
    output logic [PC_W-1:0] o_pc4
);

    logic            r_valid;
    logic [31:0]     r_instr;
    logic [PC_W-1:0] r_pc4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc4   <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : MIPS instruction fetch stage. Holds the PC, issues requests to
//               instruction memory, registers fetched words into the IF/ID
//               output register and honours decode stall and branch/jump
//               redirect.
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem              : instruction-memory bus (master side)
//   i_stall           : decode cannot accept this cycle
//   i_redirect_valid  : flush and refetch from i_redirect_pc
//   i_redirect_pc     : redirect target, low two bits ignored
//   o_if_instr        : IF/ID instruction (NOP_INSTR when invalid)
//   o_if_op           : o_if_instr[31:26], decoder op input
//   o_if_pc4          : PC of o_if_instr plus 4
//   o_if_valid        : o_if_instr holds a live instruction
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [PC_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stage_if.master        imem,
    input  logic                 i_stall,
    input  logic                 i_redirect_valid,
    input  logic [PC_W-1:0]      i_redirect_pc,
    output logic [31:0]          o_if_instr,
    output logic [OP_MSB-OP_LSB:0] o_if_op,
    output logic [PC_W-1:0]      o_if_pc4,
    output logic                 o_if_valid
);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_drop_addr;
    logic [31:0]     r_if_instr;
    logic [PC_W-1:0] r_if_pc4;
    logic            r_if_valid;

    logic            w_consume;
    logic            w_out_free;
    logic            w_accept;
    logic            w_load_fetch;
    logic            w_skid_load;
    logic            w_skid_drain;
    logic            w_skid_valid;
    logic [31:0]     w_skid_instr;
    logic [PC_W-1:0] w_skid_pc4;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_redirect_target;

    assign w_consume         = r_if_valid & ~i_stall;
    assign w_out_free        = ~r_if_valid | ~i_stall;
    // A word is only taken from memory in REQ; redirect discards it.
    assign w_accept          = (r_state == REQ) & imem.imem_ready & ~i_redirect_valid;
    assign w_load_fetch      = w_accept & w_out_free;
    assign w_skid_load       = w_accept & ~w_out_free;
    assign w_skid_drain      = w_skid_valid & w_consume & ~i_redirect_valid;
    assign w_pc_plus4        = r_pc + 32'd4;
    assign w_redirect_target = align_word(i_redirect_pc);

    fetch_skid #(
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_clear (i_redirect_valid),
        .i_instr (imem.imem_rdata),
        .i_pc4   (w_pc_plus4),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_pc4   (w_skid_pc4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= align_word(RESET_PC);
            r_drop_addr <= align_word(RESET_PC);
            r_if_instr  <= NOP_INSTR;
            r_if_pc4    <= '0;
            r_if_valid  <= 1'b0;
        end else if (i_redirect_valid) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            r_pc       <= w_redirect_target;
            case (r_state)
                // Memory still owes us a word for the old address: keep the
                // request alive on that address and throw the data away.
                REQ: begin
                    if (!imem.imem_ready) begin
                        r_drop_addr <= r_pc;
                        r_state     <= DROP;
                    end
                end
                DROP: begin
                    if (imem.imem_ready) begin
                        r_state <= REQ;
                    end
                end
                default: r_state <= REQ;
            endcase
        end else begin
            if (w_load_fetch) begin
                r_if_instr <= imem.imem_rdata;
                r_if_pc4   <= w_pc_plus4;
                r_if_valid <= 1'b1;
            end else if (w_skid_drain) begin
                r_if_instr <= w_skid_instr;
                r_if_pc4   <= w_skid_pc4;
                r_if_valid <= 1'b1;
            end else if (w_consume) begin
                r_if_instr <= NOP_INSTR;
                r_if_valid <= 1'b0;
            end

            case (r_state)
                IDLE: r_state <= REQ;
                REQ: begin
                    if (imem.imem_ready) begin
                        r_pc <= w_pc_plus4;
                        if (!w_out_free) begin
                            r_state <= WAIT;
                        end
                    end
                end
                DROP: begin
                    if (imem.imem_ready) begin
                        r_state <= REQ;
                    end
                end
                WAIT: begin
                    if (w_skid_drain) begin
                        r_state <= REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Decoded from the state register only, so reset removes the request
    // immediately.
    assign imem.imem_req  = (r_state == REQ) || (r_state == DROP);
    assign imem.imem_addr = (r_state == DROP) ? r_drop_addr : r_pc;

    assign o_if_instr = r_if_instr;
    assign o_if_op    = r_if_instr[OP_MSB:OP_LSB];
    assign o_if_pc4   = r_if_pc4;
    assign o_if_valid = r_if_valid;

endmodule
`default_nettype wire
